// File: rtl/subleq_ctrl.sv
// subleq_ctrl: SUBLEQ instruction sequencer.
// Fetches A, B, C at pc..pc+2, reads mem[A] and mem[B], and writes
// mem[B] - mem[A] back to mem[B]. If the result is <= 0 it branches to C,
// otherwise it continues at pc+3. A taken branch to HALT_ADDR stops the machine.
//
// Memory port: mem_addr, mem_rd and mem_wr are registered. Each one is
// computed from the next state, so it is visible during the cycle its
// state is current. Read data arrives on mem_rdata the cycle after mem_rd.
// A write takes effect at the clock edge that ends the cycle in which
// mem_wr is high. The write data depends on the read data returning
// during EX, so mem_wdata is a combinational output. It is zero outside EX.
module subleq_ctrl #(
  parameter logic [7:0] HALT_ADDR = 8'hFF,
  parameter int         CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [7:0]       start_pc,
  output logic [7:0]       mem_addr,
  output logic             mem_rd,
  input  logic [7:0]       mem_rdata,
  output logic             mem_wr,
  output logic [7:0]       mem_wdata,
  output logic [7:0]       pc,
  output logic             busy,
  output logic             halted,
  output logic [CNT_W-1:0] instr_cnt,
  output logic [2:0]       dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_FA   = 3'd1,
    S_FB   = 3'd2,
    S_FC   = 3'd3,
    S_RA   = 3'd4,
    S_RB   = 3'd5,
    S_EX   = 3'd6,
    S_HALT = 3'd7
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       a, b, c, opa;
  logic [7:0]       pc_d, addr_d, res;
  logic             rd_d, wr_d, take;
  logic [CNT_W-1:0] cnt_d;

  assign dbg_state = state_q;
  assign busy      = (state_q != S_IDLE) && (state_q != S_HALT);
  assign halted    = (state_q == S_HALT);
  assign res       = mem_rdata - opa;
  assign take      = res[7] | (res == 8'd0);
  assign mem_wdata = (state_q == S_EX) ? res : 8'd0;

  // Choose the next state, the next pc and counter, and the registered port values for that state.
  always_comb begin
    state_d = state_q;
    pc_d    = pc;
    cnt_d   = instr_cnt;
    addr_d  = 8'd0;
    rd_d    = 1'b0;
    wr_d    = 1'b0;
    case (state_q)
      S_IDLE, S_HALT: begin
        if (start) begin
          state_d = S_FA;
          pc_d    = start_pc;
          cnt_d   = '0;
          addr_d  = start_pc;
          rd_d    = 1'b1;
        end
      end
      S_FA: begin
        state_d = S_FB;
        addr_d  = pc + 8'd1;
        rd_d    = 1'b1;
      end
      S_FB: begin
        state_d = S_FC;
        addr_d  = pc + 8'd2;
        rd_d    = 1'b1;
      end
      S_FC: begin
        state_d = S_RA;
        addr_d  = a;
        rd_d    = 1'b1;
      end
      S_RA: begin
        state_d = S_RB;
        addr_d  = b;
        rd_d    = 1'b1;
      end
      S_RB: begin
        state_d = S_EX;
        addr_d  = b;
        wr_d    = 1'b1;
      end
      S_EX: begin
        pc_d = take ? c : pc + 8'd3;
        if (instr_cnt != {CNT_W{1'b1}}) cnt_d = instr_cnt + CNT_W'(1);
        if (take && (c == HALT_ADDR)) begin
          state_d = S_HALT;
        end else begin
          state_d = S_FA;
          addr_d  = pc_d;
          rd_d    = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Register the state, pc, counter and memory port, and capture the operands each fetch returns.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pc        <= 8'd0;
      a         <= 8'd0;
      b         <= 8'd0;
      c         <= 8'd0;
      opa       <= 8'd0;
      mem_addr  <= 8'd0;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
      instr_cnt <= '0;
    end else begin
      state_q   <= state_d;
      pc        <= pc_d;
      instr_cnt <= cnt_d;
      mem_addr  <= addr_d;
      mem_rd    <= rd_d;
      mem_wr    <= wr_d;
      if (state_q == S_FB) a   <= mem_rdata;
      if (state_q == S_FC) b   <= mem_rdata;
      if (state_q == S_RA) c   <= mem_rdata;
      if (state_q == S_RB) opa <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_subleq_ctrl.sv
// tb_subleq_ctrl: directed bench for subleq_ctrl with a 256x8 synchronous memory model.
module tb_subleq_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  start_pc = 8'd0;
  logic [7:0]  mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_rdata = 8'd0;
  logic        mem_wr;
  logic [7:0]  mem_wdata;
  logic [7:0]  pc;
  logic        busy;
  logic        halted;
  logic [15:0] instr_cnt;
  logic [2:0]  dbg_state;

  logic [7:0]  mem [256];
  logic [7:0]  ref_mem [256];
  logic        clr = 1'b0;
  logic        ld_en = 1'b0;
  logic [7:0]  ld_addr = 8'd0;
  logic [7:0]  ld_data = 8'd0;

  logic [16:0] exp_q [$];
  logic [16:0] obs_q [$];
  int          checks = 0;
  int          failures = 0;
  int          both_cnt = 0;

  logic [7:0]  epc;
  bit          ehalt;

  subleq_ctrl #(.HALT_ADDR(8'hFF), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .start_pc(start_pc),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata),
    .mem_wr(mem_wr), .mem_wdata(mem_wdata), .pc(pc), .busy(busy),
    .halted(halted), .instr_cnt(instr_cnt), .dbg_state(dbg_state)
  );

  // Clock.
  always #5 clk = ~clk;

  // Memory model: clear/load from the bench, write from the DUT, registered read.
  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'd0;
    end else if (ld_en) begin
      mem[ld_addr] <= ld_data;
    end else if (mem_wr) begin
      mem[mem_addr] <= mem_wdata;
    end
    if (mem_rd) mem_rdata <= mem[mem_addr];
  end

  // Record every memory access the DUT makes.
  always @(negedge clk) begin
    if (!rst && (mem_rd || mem_wr))
      obs_q.push_back({mem_wr, mem_addr, (mem_wr ? mem_wdata : 8'h00)});
    if (mem_rd && mem_wr) both_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'd0;
    rst = 1'b0;
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic load(input logic [7:0] addr, input logic [7:0] val);
    ld_en = 1'b1;
    ld_addr = addr;
    ld_data = val;
    @(negedge clk);
    ld_en = 1'b0;
    ref_mem[addr] = val;
  endtask

  // Reference model: predicts the access sequence and the final pc for n instructions.
  task automatic model_run(input logic [7:0] spc, input int n, output logic [7:0] fpc, output bit fhalt);
    logic [7:0] p, a, b, c, p1, p2, res;
    p = spc;
    fhalt = 1'b0;
    for (int i = 0; i < n; i++) begin
      p1 = p + 8'd1;
      p2 = p + 8'd2;
      a = ref_mem[p];
      b = ref_mem[p1];
      c = ref_mem[p2];
      exp_q.push_back({1'b0, p, 8'h00});
      exp_q.push_back({1'b0, p1, 8'h00});
      exp_q.push_back({1'b0, p2, 8'h00});
      exp_q.push_back({1'b0, a, 8'h00});
      exp_q.push_back({1'b0, b, 8'h00});
      res = ref_mem[b] - ref_mem[a];
      exp_q.push_back({1'b1, b, res});
      ref_mem[b] = res;
      if ($signed(res) <= 0) begin
        p = c;
        if (c == 8'hFF) fhalt = 1'b1;
      end else begin
        p = p + 8'd3;
      end
    end
    fpc = p;
  endtask

  task automatic compare_sb(input string tag);
    logic [16:0] e, o;
    int n;
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      e = exp_q.pop_front();
      if (obs_q.size() > 0) o = obs_q.pop_front();
      else o = 'x;
      chk(tag, {15'd0, o}, {15'd0, e});
    end
    obs_q.delete();
  endtask

  task automatic pulse_start(input logic [7:0] spc);
    start = 1'b1;
    start_pc = spc;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic load_basic(input logic [7:0] m11);
    load(8'h00, 8'h10);
    load(8'h01, 8'h11);
    load(8'h02, 8'h05);
    load(8'h10, 8'h05);
    load(8'h11, m11);
  endtask

  initial begin
    // Reset state.
    do_reset();
    chk("rst_mem_addr", mem_addr, 8'h00);
    chk("rst_mem_rd", mem_rd, 1'b0);
    chk("rst_mem_wr", mem_wr, 1'b0);
    chk("rst_mem_wdata", mem_wdata, 8'h00);
    chk("rst_pc", pc, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_halted", halted, 1'b0);
    chk("rst_cnt", instr_cnt, 16'd0);
    chk("rst_state", dbg_state, 3'd0);

    // No branch: 7 - 5 = 2.
    do_reset();
    load_basic(8'h07);
    model_run(8'h00, 1, epc, ehalt);
    pulse_start(8'h00);
    chk("nb_busy_fa", busy, 1'b1);
    chk("nb_state_fa", dbg_state, 3'd1);
    step(5);
    chk("nb_wr_ex", mem_wr, 1'b1);
    chk("nb_wdata_ex", mem_wdata, 8'h02);
    step(1);
    chk("nb_pc", pc, 8'h03);
    chk("nb_pc_model", pc, epc);
    chk("nb_cnt", instr_cnt, 16'd1);
    chk("nb_mem11", mem[8'h11], 8'h02);
    compare_sb("nb_access");

    // Branch on zero: 5 - 5 = 0.
    do_reset();
    load_basic(8'h05);
    model_run(8'h00, 1, epc, ehalt);
    pulse_start(8'h00);
    step(6);
    chk("bz_pc", pc, 8'h05);
    chk("bz_mem11", mem[8'h11], 8'h00);
    compare_sb("bz_access");

    // Branch on negative: 3 - 5 = FE.
    do_reset();
    load_basic(8'h03);
    model_run(8'h00, 1, epc, ehalt);
    pulse_start(8'h00);
    step(6);
    chk("bn_pc", pc, 8'h05);
    chk("bn_mem11", mem[8'h11], 8'hFE);
    compare_sb("bn_access");

    // Halt with A==B, then restart at 40.
    do_reset();
    load(8'h00, 8'h20);
    load(8'h01, 8'h20);
    load(8'h02, 8'hFF);
    load(8'h20, 8'h33);
    load(8'h40, 8'h50);
    load(8'h41, 8'h51);
    load(8'h42, 8'hFF);
    load(8'h50, 8'h01);
    load(8'h51, 8'h01);
    model_run(8'h00, 1, epc, ehalt);
    pulse_start(8'h00);
    step(5);
    chk("h_halted_in_ex", halted, 1'b0);
    step(1);
    chk("h_halted", halted, 1'b1);
    chk("h_busy", busy, 1'b0);
    chk("h_pc", pc, epc);
    chk("h_model_halt", ehalt, 1'b1);
    chk("h_mem20", mem[8'h20], 8'h00);
    step(4);
    chk("h_quiet_rd", mem_rd, 1'b0);
    chk("h_quiet_count", obs_q.size(), 32'd6);
    compare_sb("h_access");
    model_run(8'h40, 1, epc, ehalt);
    pulse_start(8'h40);
    chk("h_restart_cnt", instr_cnt, 16'd0);
    chk("h_restart_pc", pc, 8'h40);
    chk("h_restart_busy", busy, 1'b1);
    step(6);
    chk("h_restart_halted", halted, 1'b1);
    chk("h_restart_cnt1", instr_cnt, 16'd1);
    compare_sb("h_restart_access");

    // PC wrap: start at FE.
    do_reset();
    load(8'hFE, 8'h10);
    load(8'hFF, 8'h11);
    load(8'h00, 8'h30);
    load(8'h10, 8'h05);
    load(8'h11, 8'h07);
    model_run(8'hFE, 1, epc, ehalt);
    pulse_start(8'hFE);
    step(6);
    chk("wr_pc", pc, 8'h01);
    compare_sb("wr_access");

    // start held high during FB..EX; signed edge 80 - 01 = 7F, not taken; then halt.
    do_reset();
    load(8'h00, 8'h10);
    load(8'h01, 8'h11);
    load(8'h02, 8'h05);
    load(8'h10, 8'h01);
    load(8'h11, 8'h80);
    load(8'h03, 8'h12);
    load(8'h04, 8'h12);
    load(8'h05, 8'hFF);
    load(8'h12, 8'h09);
    model_run(8'h00, 2, epc, ehalt);
    pulse_start(8'h00);
    step(1);
    start = 1'b1;
    start_pc = 8'h77;
    step(4);
    chk("sg_wdata", mem_wdata, 8'h7F);
    step(1);
    start = 1'b0;
    chk("sg_pc", pc, 8'h03);
    chk("sg_mem11", mem[8'h11], 8'h7F);
    step(6);
    chk("sg_halted", halted, 1'b1);
    chk("sg_pc_end", pc, epc);
    chk("sg_cnt", instr_cnt, 16'd2);
    compare_sb("sg_access");

    // Reset during RB aborts the instruction with no write.
    do_reset();
    load_basic(8'h07);
    pulse_start(8'h00);
    step(4);
    chk("ar_state_rb", dbg_state, 3'd5);
    rst = 1'b1;
    #1;
    chk("ar_state", dbg_state, 3'd0);
    chk("ar_addr", mem_addr, 8'h00);
    chk("ar_rd", mem_rd, 1'b0);
    chk("ar_wr", mem_wr, 1'b0);
    chk("ar_pc", pc, 8'h00);
    chk("ar_busy", busy, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    obs_q.delete();
    step(10);
    chk("ar_no_access", obs_q.size(), 32'd0);
    chk("ar_mem11", mem[8'h11], 8'h07);

    chk("no_rd_wr_overlap", both_cnt, 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/subleq_ctrl.md
# subleq_ctrl

Instruction sequencer for the SUBLEQ one-instruction CPU. Owns the program counter, fetches the three operand addresses A, B, C of each instruction, reads mem[A] and mem[B], writes mem[B] − mem[A] back to mem[B], and branches to C when the result is ≤ 0. It drives the single shared 256×8 memory port and is the only master on it; the 8-bit 2:1 address muxes in the datapath are replaced by this block's registered address output.

## Interface
Parameters:
- HALT_ADDR, 8'hFF, branch target that halts the machine.
- CNT_W, 16, width of retired-instruction counter.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin execution at start_pc; sampled only in IDLE or HALT.
- start_pc  in  8  initial PC loaded on accepted start.
- mem_addr  out  8  memory address, registered.
- mem_rd  out  1  read strobe; data returned on mem_rdata next cycle.
- mem_rdata  in  8  read data, valid the cycle after mem_rd.
- mem_wr  out  1  write strobe; mem_wdata written to mem_addr at the edge.
- mem_wdata  out  8  write data.
- pc  out  8  current program counter.
- busy  out  1  high in any fetch/execute state.
- halted  out  1  high in HALT.
- instr_cnt  out  CNT_W  retired instructions since last accepted start; saturates at all-ones.

## Operation
- States: IDLE, FA, FB, FC, RA, RB, EX, HALT.
- IDLE: outputs quiescent. start=1 → pc ← start_pc, instr_cnt ← 0, go to FA.
- FA: mem_rd=1, mem_addr=pc → FB.
- FB: a ← mem_rdata; mem_rd=1, mem_addr=pc+1 → FC.
- FC: b ← mem_rdata; mem_rd=1, mem_addr=pc+2 → RA.
- RA: c ← mem_rdata; mem_rd=1, mem_addr=a → RB.
- RB: opa ← mem_rdata; mem_rd=1, mem_addr=b → EX.
- EX: res = mem_rdata − opa (8-bit two's complement, wrap, no overflow flag); mem_wr=1, mem_addr=b, mem_wdata=res; take = res[7] | (res==0); pc ← take ? c : pc+3; instr_cnt increments (saturating). If take and c==HALT_ADDR → HALT, else → FA.
- HALT: halted=1, busy=0, no memory access. start=1 → same as IDLE start.
- start ignored in FA..EX.
- All PC arithmetic mod 256: pc+1, pc+2, pc+3 wrap (pc=8'hFE fetches FE, FF, 00; next pc 01).
- A==B allowed: result 0, mem[B] ← 0, branch taken.
- Self-modifying code allowed: the write in EX is visible to the next FA fetch.
- mem_rd and mem_wr never both high.

## Timing
- Reset (async, any state): state IDLE; pc, a, b, c, opa, mem_addr, mem_wdata = 0; mem_rd, mem_wr, busy, halted = 0; instr_cnt = 0. Reset mid-instruction aborts it with no write.
- Memory outputs are registered: the strobe/address for a state appear the cycle that state is current.
- Exactly 6 cycles per instruction (FA..EX); first FA the cycle after start is accepted.
- pc, instr_cnt update at the EX→next edge; halted rises the cycle after the halting EX.
- busy = 1 in FA..EX only.

## Test plan
- Reset: assert rst mid-RB → all outputs 0, state IDLE immediately; no mem_wr seen afterwards without start.
- No branch: mem[0..2]={10,11,05}, mem[10]=05, mem[11]=07, start_pc=0 → after 6 cycles mem[11]=02, pc=03, instr_cnt=1.
- Branch on zero/negative: mem[11]=05 → mem[11]=00, pc=05; repeat with mem[11]=03 → mem[11]=FE, pc=05.
- Halt: instr {20,20,FF} at 00 → mem[20]=00, halted=1 one cycle after EX, busy=0, no further strobes; start with start_pc=40 restarts, instr_cnt=0.
- Wrap: start_pc=FE, mem[FE]=10, mem[FF]=11, mem[00]=30, no branch → fetch addrs FE, FF, 00; pc=01.
- start pulsed during FB..EX → ignored, pc sequence unchanged; signed edge 80−01 → 7F, not taken.
